// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order imem reads, tagged with their PC and buffered for decode.
// Define IF_PERF_CNT_EN to add saturating stall/drop performance counters.
module if_fetch_unit #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            enable_design,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  output logic            stage_IF_ready,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_valid_o,
  input  logic            id_ready_i
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cnt_o,
  output logic [31:0]     perf_drop_cnt_o
`endif
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic {IDLE, REQ} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;

  logic [XLEN-1:0] tag_mem_q [DEPTH];
  logic [XLEN-1:0] tag_mem_d [DEPTH];
  logic [AW-1:0]   tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [CW-1:0]   tag_cnt_q, tag_cnt_d;

  logic [XLEN-1:0] ipc_mem_q [DEPTH];
  logic [XLEN-1:0] ipc_mem_d [DEPTH];
  logic [XLEN-1:0] idat_mem_q [DEPTH];
  logic [XLEN-1:0] idat_mem_d [DEPTH];
  logic [AW-1:0]   inst_wp_q, inst_wp_d, inst_rp_q, inst_rp_d;
  logic [CW-1:0]   inst_cnt_q, inst_cnt_d;

  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic accept, gnt, rsp, rsp_drop, rsp_keep, pop;
  logic tag_push, tag_pop, credit_ok;

  assign credit_ok      = ({1'b0, outstanding_q} + {1'b0, inst_cnt_q}) < DEPTH_C;
  assign stage_IF_ready = enable_design & ~flush_i & (state_q == IDLE) & credit_ok;
  assign accept         = pc_valid_i & stage_IF_ready;
  assign gnt            = (state_q == REQ) & imem_gnt_i;
  assign rsp            = imem_rvalid_i & (outstanding_q != '0);
  assign rsp_drop       = rsp & (drop_cnt_q != '0);
  assign rsp_keep       = rsp & (drop_cnt_q == '0);
  assign pop            = inst_valid_o & id_ready_i & enable_design;
  assign tag_push       = gnt & ~flush_i;
  // A dropped response pops a tag only while stale pre-flush tags remain at the head;
  // a request granted in the flush cycle has no tag, so this keeps later tags aligned.
  assign tag_pop        = rsp_keep | (rsp_drop & (tag_cnt_q > (outstanding_q - drop_cnt_q)));

  assign imem_req_o   = (state_q == REQ);
  assign imem_addr_o  = req_addr_q;
  assign inst_valid_o = (inst_cnt_q != '0);
  assign inst_o       = idat_mem_q[inst_rp_q];
  assign inst_pc_o    = ipc_mem_q[inst_rp_q];

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    tag_mem_d     = tag_mem_q;
    tag_wp_d      = tag_wp_q;
    tag_rp_d      = tag_rp_q;
    ipc_mem_d     = ipc_mem_q;
    idat_mem_d    = idat_mem_q;
    inst_wp_d     = inst_wp_q;
    inst_rp_d     = inst_rp_q;
    inst_cnt_d    = inst_cnt_q;
    outstanding_d = outstanding_q + CW'(gnt) - CW'(rsp);
    drop_cnt_d    = drop_cnt_q - CW'(rsp_drop);

    if (flush_i) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d    = REQ;
      req_addr_d = pc_i;
    end else if (gnt) begin
      state_d = IDLE;
    end

    if (tag_push) begin
      tag_mem_d[tag_wp_q] = req_addr_q;
      tag_wp_d            = tag_wp_q + AW'(1);
    end
    if (tag_pop) begin
      tag_rp_d = tag_rp_q + AW'(1);
    end
    tag_cnt_d = tag_cnt_q + CW'(tag_push) - CW'(tag_pop);

    if (flush_i) begin
      inst_wp_d  = '0;
      inst_rp_d  = '0;
      inst_cnt_d = '0;
      drop_cnt_d = outstanding_d;
    end else begin
      if (rsp_keep) begin
        ipc_mem_d[inst_wp_q]  = tag_mem_q[tag_rp_q];
        idat_mem_d[inst_wp_q] = imem_rdata_i;
        inst_wp_d             = inst_wp_q + AW'(1);
      end
      if (pop) begin
        inst_rp_d = inst_rp_q + AW'(1);
      end
      inst_cnt_d = inst_cnt_q + CW'(rsp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      req_addr_q    <= '0;
      tag_wp_q      <= '0;
      tag_rp_q      <= '0;
      tag_cnt_q     <= '0;
      inst_wp_q     <= '0;
      inst_rp_q     <= '0;
      inst_cnt_q    <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_mem_q[i]  <= '0;
        ipc_mem_q[i]  <= '0;
        idat_mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      tag_mem_q     <= tag_mem_d;
      tag_wp_q      <= tag_wp_d;
      tag_rp_q      <= tag_rp_d;
      tag_cnt_q     <= tag_cnt_d;
      ipc_mem_q     <= ipc_mem_d;
      idat_mem_q    <= idat_mem_d;
      inst_wp_q     <= inst_wp_d;
      inst_rp_q     <= inst_rp_d;
      inst_cnt_q    <= inst_cnt_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] pdrop_cnt_q, pdrop_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    pdrop_cnt_d = pdrop_cnt_q;
    if (pc_valid_i && enable_design && !stage_IF_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (rsp_drop && (pdrop_cnt_q != '1)) begin
      pdrop_cnt_d = pdrop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_cnt_q <= '0;
      pdrop_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      pdrop_cnt_q <= pdrop_cnt_d;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_drop_cnt_o  = pdrop_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random traffic against a queue-based fetch model.
module tb_if_fetch_unit;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            enable_design;
  logic [XLEN-1:0] pc_i;
  logic            pc_valid_i;
  logic            stage_IF_ready;
  logic            flush_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] inst_pc_o;
  logic            inst_valid_o;
  logic            id_ready_i;
`ifdef IF_PERF_CNT_EN
  logic [31:0]     perf_stall_cnt_o;
  logic [31:0]     perf_drop_cnt_o;
`endif

  if_fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .enable_design  (enable_design),
    .pc_i           (pc_i),
    .pc_valid_i     (pc_valid_i),
    .stage_IF_ready (stage_IF_ready),
    .flush_i        (flush_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .inst_valid_o   (inst_valid_o),
    .id_ready_i     (id_ready_i)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_drop_cnt_o  (perf_drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    bit          killed;
  } fl_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  // Model: requests granted but not yet answered, and the instruction buffer contents.
  fl_t         inflight[$];
  ent_t        outq[$];
  bit          m_pending;
  logic [31:0] m_addr;
  logic [31:0] m_stall, m_drop;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  logic [31:0] obs_pc[$];
  logic [31:0] obs_dat[$];
  int unsigned obs_cyc[$];

  bit          rnd, k_en, k_fl, k_idr, k_gnt, k_rv, acc_now;
  logic [31:0] pc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic bit model_ready();
    return enable_design && !flush_i && !m_pending && ((inflight.size() + outq.size()) < DEPTH);
  endfunction

  function automatic logic [31:0] obs_at(input int unsigned i);
    return (obs_pc.size() > i) ? obs_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dat_at(input int unsigned i);
    return (obs_dat.size() > i) ? obs_dat[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int unsigned cyc_at(input int unsigned i);
    return (obs_cyc.size() > i) ? obs_cyc[i] : 32'hFFFF;
  endfunction

  always @(negedge clk_i) begin : cmp
    fl_t  e;
    ent_t n;
    bit   exp_rdy, rsp_evt, gnt_evt, pop_evt, acc_evt;
    cyc++;
    if (!reset_i) begin
      chk("rst_imem_req", imem_req_o, 0);
      chk("rst_imem_addr", imem_addr_o, 0);
      chk("rst_inst_valid", inst_valid_o, 0);
      chk("rst_inst", inst_o, 0);
      chk("rst_inst_pc", inst_pc_o, 0);
      inflight.delete();
      outq.delete();
      m_pending = 0;
      m_addr    = '0;
      m_stall   = '0;
      m_drop    = '0;
    end else begin
      assert (!(imem_rvalid_i && inflight.size() == 0))
        else $error("bench drove rvalid with no request outstanding");
      exp_rdy = model_ready();
      chk("stage_IF_ready", stage_IF_ready, exp_rdy);
      chk("imem_req_o", imem_req_o, m_pending);
      if (m_pending) chk("imem_addr_o", imem_addr_o, m_addr);
      chk("inst_valid_o", inst_valid_o, outq.size() != 0);
      if (outq.size() != 0) begin
        chk("inst_pc_o", inst_pc_o, outq[0].pc);
        chk("inst_o", inst_o, outq[0].data);
      end
`ifdef IF_PERF_CNT_EN
      chk("perf_stall", perf_stall_cnt_o, m_stall);
      chk("perf_drop", perf_drop_cnt_o, m_drop);
`endif
      if (inst_valid_o && id_ready_i && enable_design) begin
        obs_pc.push_back(inst_pc_o);
        obs_dat.push_back(inst_o);
        obs_cyc.push_back(cyc);
      end

      rsp_evt = imem_rvalid_i && (inflight.size() != 0);
      gnt_evt = m_pending && imem_gnt_i;
      pop_evt = (outq.size() != 0) && id_ready_i && enable_design;
      acc_evt = pc_valid_i && exp_rdy;
      if (pc_valid_i && enable_design && !exp_rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (pop_evt) void'(outq.pop_front());
      if (rsp_evt) begin
        e = inflight.pop_front();
        if (e.killed) begin
          if (m_drop != 32'hFFFF_FFFF) m_drop++;
        end else begin
          n.pc   = e.addr;
          n.data = imem_rdata_i;
          outq.push_back(n);
        end
      end
      if (gnt_evt) begin
        e.addr   = m_addr;
        e.killed = 0;
        inflight.push_back(e);
        m_pending = 0;
      end
      if (flush_i) begin
        foreach (inflight[i]) inflight[i].killed = 1;
        outq.delete();
        m_pending = 0;
      end
      if (acc_evt) begin
        m_pending = 1;
        m_addr    = pc_i;
      end
    end
  end

  task automatic apply();
    bit rvk;
    if (rnd) begin
      enable_design = ($urandom_range(0, 9) != 0);
      flush_i       = ($urandom_range(0, 24) == 0);
      id_ready_i    = ($urandom_range(0, 2) != 0);
      imem_gnt_i    = ($urandom_range(0, 1) == 1);
      rvk           = ($urandom_range(0, 2) != 0);
      pc_valid_i    = ($urandom_range(0, 3) != 0);
      pc_i          = $urandom & 32'hFFFF_FFFC;
    end else begin
      enable_design = k_en;
      flush_i       = k_fl;
      id_ready_i    = k_idr;
      imem_gnt_i    = k_gnt;
      rvk           = k_rv;
      pc_valid_i    = (pc_q.size() != 0);
      pc_i          = pc_valid_i ? pc_q[0] : '0;
    end
    imem_rvalid_i = rvk && (inflight.size() != 0);
    imem_rdata_i  = imem_rvalid_i ? mem_data(inflight[0].addr) : $urandom;
    acc_now       = pc_valid_i && model_ready();
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (acc_now && !rnd && pc_q.size() != 0) void'(pc_q.pop_front());
  endtask

  task automatic run(input int unsigned n);
    repeat (n) begin
      apply();
      tick();
    end
  endtask

  task automatic clear_obs();
    obs_pc.delete();
    obs_dat.delete();
    obs_cyc.delete();
  endtask

  initial begin
    rnd = 0; k_en = 1; k_fl = 0; k_idr = 1; k_gnt = 0; k_rv = 0;
    reset_i = 1'b0; enable_design = 1'b1; pc_i = 32'h100; pc_valid_i = 1'b1;
    flush_i = 1'b0; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678;
    id_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #2;
    chk("reset_req", imem_req_o, 0);
    chk("reset_valid", inst_valid_o, 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    pc_q = '{32'h100};
    apply();
    chk("ready_after_reset", stage_IF_ready, 1);
    tick();
    apply();
    chk("first_req", imem_req_o, 1);
    chk("first_addr", imem_addr_o, 32'h100);
    chk("ready_in_req", stage_IF_ready, 0);
    tick();

    // Stream with immediate grant and one-cycle response.
    clear_obs();
    k_gnt = 1; k_rv = 1; k_idr = 1;
    pc_q = '{32'h104, 32'h108};
    run(12);
    chk("stream_count", obs_pc.size(), 3);
    chk("stream_pc0", obs_at(0), 32'h100);
    chk("stream_pc1", obs_at(1), 32'h104);
    chk("stream_pc2", obs_at(2), 32'h108);
    chk("stream_dat0", dat_at(0), 32'hA5A5_0100);
    chk("stream_dat2", dat_at(2), 32'hA5A5_0108);
    chk("stream_gap01", (cyc_at(1) - cyc_at(0)) <= 2, 1);
    chk("stream_gap12", (cyc_at(2) - cyc_at(1)) <= 2, 1);

    // Backpressure: two buffered/outstanding fetches exhaust the credits.
    clear_obs();
    k_idr = 0;
    pc_q = '{32'h200, 32'h204, 32'h208};
    run(10);
    repeat (3) begin
      apply();
      chk("bp_stalled", stage_IF_ready, 0);
      tick();
    end
    k_idr = 1;
    apply();
    chk("bp_pop_cycle_ready", stage_IF_ready, 0);
    chk("bp_head_pc", inst_pc_o, 32'h200);
    tick();
    k_idr = 0;
    apply();
    chk("bp_credit_back", stage_IF_ready, 1);
    tick();
    k_idr = 1;
    run(10);
    chk("bp_count", obs_pc.size(), 3);
    chk("bp_pc0", obs_at(0), 32'h200);
    chk("bp_pc2", obs_at(2), 32'h208);

    // Flush with two granted requests still in flight.
    k_rv = 0;
    pc_q = '{32'h300, 32'h304};
    run(6);
    clear_obs();
    pc_q = '{32'h400};
    k_fl = 1;
    apply();
    chk("ff_no_accept", stage_IF_ready, 0);
    tick();
    k_fl = 0; k_rv = 1;
    run(12);
    chk("ff_count", obs_pc.size(), 1);
    chk("ff_first_pc", obs_at(0), 32'h400);
    chk("ff_first_dat", dat_at(0), 32'hA5A5_0400);
`ifdef IF_PERF_CNT_EN
    chk("ff_perf_drop", perf_drop_cnt_o, 2);
`endif

    // Flush while a request waits for grant.
    clear_obs();
    k_gnt = 0;
    pc_q = '{32'h500};
    run(1);
    apply();
    chk("fr_req", imem_req_o, 1);
    chk("fr_addr", imem_addr_o, 32'h500);
    tick();
    k_fl = 1;
    apply();
    tick();
    k_fl = 0;
    apply();
    chk("fr_req_dropped", imem_req_o, 0);
    chk("fr_ready", stage_IF_ready, 1);
    tick();
    run(3);
    pc_q = '{32'h600};
    run(1);
    apply();
    chk("fg_req", imem_req_o, 1);
    tick();
    k_fl = 1; k_gnt = 1;
    apply();
    tick();
    k_fl = 0;
    pc_q = '{32'h604};
    apply();
    chk("fg_req_dropped", imem_req_o, 0);
    tick();
    run(12);
    chk("fg_count", obs_pc.size(), 1);
    chk("fg_first_pc", obs_at(0), 32'h604);
`ifdef IF_PERF_CNT_EN
    chk("fg_perf_drop", perf_drop_cnt_o, 3);
`endif

    // Global disable holds a buffered instruction.
    k_idr = 0;
    pc_q = '{32'h700};
    run(6);
    clear_obs();
    k_en = 0; k_idr = 1;
    repeat (3) begin
      apply();
      chk("dis_valid", inst_valid_o, 1);
      chk("dis_pc", inst_pc_o, 32'h700);
      chk("dis_ready", stage_IF_ready, 0);
      tick();
    end
    chk("dis_no_pop", obs_pc.size(), 0);
    k_en = 1;
    apply();
    tick();
    k_idr = 0;
    apply();
    chk("en_popped", inst_valid_o, 0);
    chk("en_pop_count", obs_pc.size(), 1);
    tick();

    // Random traffic against the model.
    rnd = 1;
    run(4000);
    rnd = 0;
    k_en = 1; k_fl = 0; k_idr = 1; k_gnt = 1; k_rv = 1;
    pc_q.delete();
    run(20);
    chk("drained_valid", inst_valid_o, 0);
    chk("drained_req", imem_req_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage on the consumer side of the pc unit's pc_o/pc_valid interface.
- Returns stage_IF_ready to the pc unit and issues in-order reads to instruction memory.
- Buffers returned instructions with their PC and hands them to decode over a valid/ready handshake.
- On a control-flow redirect, flushes buffered instructions and discards responses still in flight.

Parameters:
DEPTH, 2, max fetches in flight plus buffered (credit limit); power of two, >=2
XLEN, 32, PC and instruction width

Ports:
clk_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-low reset
enable_design  in  1  global enable; 0 freezes all state (no accept, no request, no pop)
pc_i  in  XLEN  fetch address from pc unit
pc_valid_i  in  1  pc_i valid
stage_IF_ready  out  1  fetch unit accepts pc_i this cycle
flush_i  in  1  redirect (jump/branch/mispredict): kill younger fetches
imem_req_o  out  1  memory read request
imem_addr_o  out  XLEN  request address
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  in-order read response valid
imem_rdata_i  in  XLEN  response data
inst_o  out  XLEN  instruction to decode
inst_pc_o  out  XLEN  PC of inst_o
inst_valid_o  out  1  inst_o valid
id_ready_i  in  1  decode accepts inst_o

Behaviour:
- Reset values (async, reset_i=0): imem_req_o=0, imem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
  - Also cleared: FIFOs empty, outstanding=0, drop_cnt=0, FSM=IDLE.
- stage_IF_ready = enable_design & ~flush_i & (FSM==IDLE) & (outstanding + fifo_count < DEPTH). Combinational.
- Accept: pc_valid_i & stage_IF_ready at an edge latches pc_i into req_addr and moves to REQ.
- REQ: imem_req_o=1, imem_addr_o=req_addr. Address is held stable until imem_gnt_i.
  - On gnt: push req_addr into the tag FIFO, outstanding+1, return to IDLE.
  - Next accept is possible the cycle after gnt, so peak rate is 1 fetch per 2 cycles.
- Response (imem_rvalid_i):
  - Pop the tag FIFO; outstanding-1.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise push {tag, rdata} into the inst FIFO.
  - The credit rule guarantees the inst FIFO is never full on push.
- Output:
  - inst_valid_o = ~fifo_empty. inst_o/inst_pc_o show the head entry.
  - Pop when inst_valid_o & id_ready_i & enable_design.
  - First-word latency: 1 cycle from rvalid to inst_valid_o (registered FIFO).
- Simultaneous events:
  - gnt, rvalid and pop in the same cycle update counters net, e.g. outstanding unchanged when gnt and rvalid coincide.
  - Credits are evaluated on registered counts, so a pop does not free a credit until the next cycle.
- Flush (flush_i=1 at an edge), highest priority:
  - inst FIFO cleared; inst_valid_o=0 the next cycle.
  - REQ state abandoned: imem_req_o=0 next cycle, no tag pushed even if gnt coincides.
  - Coinciding gnt: the granted request's response must still be dropped, so drop_cnt += 1 for it.
  - drop_cnt loads outstanding (after same-cycle gnt/rvalid adjustment). Those responses are dropped; tags are still popped.
  - pc_i is not accepted in the flush cycle. The redirected PC is accepted from the next cycle.
- enable_design=0:
  - imem_req_o is held as-is. A pending request stays asserted to avoid protocol violation.
  - Responses are still absorbed, so memory is never back-pressured.
  - No accept and no pop.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset release with outstanding=0 are ignored.
- Protocol violation (rvalid with empty tag FIFO): ignored. Assertion in the bench.

Optional Feature:
IF_PERF_CNT_EN:
- When defined, adds outputs perf_stall_cnt_o[31:0] and perf_drop_cnt_o[31:0], both reset to 0.
  - perf_stall_cnt_o increments on each cycle with pc_valid_i & enable_design & ~stage_IF_ready.
  - perf_drop_cnt_o increments on each discarded response.
  - Both saturate at 32'hFFFF_FFFF.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset_i=0 with rvalid=1 and gnt=1 → all outputs 0. Release, then pc_i=32'h100 with valid → imem_req_o=1 and imem_addr_o=32'h100 the next cycle.
- Stream: PCs 0x100/0x104/0x108, gnt immediate, rvalid 1 cycle after gnt, data=PC^32'hA5A5_0000, id_ready_i=1 → inst_pc_o 0x100, 0x104, 0x108 in order with matching inst_o, no gaps beyond 2 cycles.
- Backpressure: id_ready_i=0, DEPTH=2 → after 2 fetches stage_IF_ready=0 and stays 0. One pop restores stage_IF_ready=1 the following cycle.
- Flush in flight: 2 requests granted, no responses, flush_i pulse, then pc_i=32'h400 → both old responses discarded, first inst_pc_o=32'h400. perf_drop_cnt_o=2 with IF_PERF_CNT_EN.
- Flush during REQ: gnt withheld, flush_i=1 → imem_req_o drops next cycle and no response is expected.
  - Repeat with gnt coinciding with flush → drop_cnt=1 and that response is discarded.
- Disable: enable_design=0 with 1 buffered instruction and id_ready_i=1 → inst_valid_o stays 1 and is not popped, stage_IF_ready=0. Re-enable → pops next edge.
